// File: rtl/bus_codes_pkg.sv
// ---------------------------------------------------------------------------
// bus_codes_pkg
// Shared definitions for the CPU datapath bus control slice.
//   - Bus source codes (one-hot position in src_out of the sequencer)
//   - Load destination codes (one-hot position in dst_in of the sequencer)
//   - Default geometry of the bus and the packed request record width
//   - Sequencer state encoding
// No ports; imported by the sequencer.
// ---------------------------------------------------------------------------
package bus_codes_pkg;

   // Default geometry of the shared bus.
   localparam int CODE_W_DEF = 5;
   localparam int N_SRC_DEF  = 26;
   localparam int N_DST_DEF  = 25;

   // A queued request is {src code, dst code, settle cycles}.
   localparam int REQ_W = 2*CODE_W_DEF + 2;

   // Bus source codes.
   localparam logic [4:0]
      SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
      SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
      SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
      SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
      SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
      SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_PORT = 5'd22, SRC_IR = 5'd23,
      SRC_MAR = 5'd24, SRC_RA  = 5'd25;

   // Load destination codes.
   localparam logic [4:0]
      DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3,
      DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7,
      DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11,
      DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15,
      DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd18, DST_MDR = 5'd19,
      DST_MAR = 5'd20, DST_IR  = 5'd21, DST_Y   = 5'd22, DST_Z   = 5'd23,
      DST_OUTPORT = 5'd24;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LATCH = 2'd2
   } seq_state_e;

endpackage

// File: rtl/xfer_fifo.sv
// ---------------------------------------------------------------------------
// xfer_fifo
// Small synchronous circular-buffer FIFO holding queued bus transfer requests.
// Ports:
//   clock    in   rising-edge clock
//   clear    in   synchronous active-low reset
//   push     in   write wr_data (ignored while full)
//   pop      in   advance past the head entry (ignored while empty)
//   flush    in   discard every entry at the next edge (beats push/pop)
//   wr_data  in   entry to write
//   rd_data  out  head entry (valid while not empty)
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries
// ---------------------------------------------------------------------------
module xfer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy. DEPTH is a power of two,
   // so the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clock) begin
      if (!clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count says valid.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// bus_transfer_sequencer
// Turns queued register-transfer requests into one-hot bus source selects
// followed by a one-hot destination load strobe.
// Ports:
//   clock      in   rising-edge clock
//   clear      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request queue not full
//   req_src    in   source code
//   req_dst    in   destination code
//   req_wait   in   extra settle cycles with the source driven before the load
//   flush      in   drop the queue and abort the current transfer
//   src_out    out  registered one-hot source select
//   dst_in     out  registered one-hot destination load enable
//   xfer_done  out  pulse aligned with the dst_in pulse
//   busy       out  queue non-empty or transfer in progress
//   err_code   out  pulse after an out-of-range request was consumed
// ---------------------------------------------------------------------------
module bus_transfer_sequencer
   import bus_codes_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int N_SRC  = N_SRC_DEF,
   parameter int N_DST  = N_DST_DEF,
   parameter int CODE_W = CODE_W_DEF
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CODE_W-1:0] req_src,
   input  logic [CODE_W-1:0] req_dst,
   input  logic [1:0]        req_wait,
   input  logic              flush,
   output logic [N_SRC-1:0]  src_out,
   output logic [N_DST-1:0]  dst_in,
   output logic              xfer_done,
   output logic              busy,
   output logic              err_code
);

   localparam int RW    = 2*CODE_W + 2;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CODE_W:0] SRC_LIM = (CODE_W+1)'(N_SRC);
   localparam logic [CODE_W:0] DST_LIM = (CODE_W+1)'(N_DST);

   seq_state_e        state_q, state_d;
   logic [CODE_W-1:0] src_code_q, src_code_d;
   logic [CODE_W-1:0] dst_code_q, dst_code_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [N_SRC-1:0]  src_out_q, src_out_d;
   logic [N_DST-1:0]  dst_in_q, dst_in_d;
   logic              xfer_done_q, xfer_done_d;
   logic              err_q, err_d;

   logic              handshake, req_bad;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [RW-1:0]     fifo_rd;
   logic [CNT_W-1:0]  fifo_count;
   logic [CODE_W-1:0] head_src, head_dst;
   logic [1:0]        head_wait;

   assign req_ready = !fifo_full;
   assign handshake = req_valid && req_ready;
   assign req_bad   = ({1'b0, req_src} >= SRC_LIM) || ({1'b0, req_dst} >= DST_LIM);
   // Bad requests still complete the handshake but never enter the queue;
   // anything arriving with flush is dropped.
   assign fifo_push = handshake && !req_bad && !flush;

   assign head_src  = fifo_rd[RW-1 -: CODE_W];
   assign head_dst  = fifo_rd[CODE_W+1 -: CODE_W];
   assign head_wait = fifo_rd[1:0];

   xfer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clock   (clock),
      .clear   (clear),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (flush),
      .wr_data ({req_src, req_dst, req_wait}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Sequencer next-state. A head entry is taken whenever the bus is free
   // (IDLE) or the current transfer is finishing (LATCH), which gives
   // back-to-back wait=0 transfers with no gap. Strobes are decoded from the
   // next state so that the outputs come straight from flops.
   always_comb begin
      state_d     = state_q;
      src_code_d  = src_code_q;
      dst_code_d  = dst_code_q;
      cnt_d       = cnt_q;
      fifo_pop    = 1'b0;
      src_out_d   = '0;
      dst_in_d    = '0;
      xfer_done_d = 1'b0;
      err_d       = handshake && req_bad && !flush;

      case (state_q)
         ST_IDLE: begin
            fifo_pop = !fifo_empty;
         end
         ST_DRIVE: begin
            if (cnt_q == 2'd1) begin
               state_d = ST_LATCH;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_LATCH: begin
            fifo_pop = !fifo_empty;
            if (fifo_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fifo_pop) begin
         src_code_d = head_src;
         dst_code_d = head_dst;
         if (head_wait == 2'd0) begin
            state_d = ST_LATCH;
         end else begin
            cnt_d   = head_wait;
            state_d = ST_DRIVE;
         end
      end

      if (flush) begin
         state_d  = ST_IDLE;
         fifo_pop = 1'b0;
      end

      for (int i = 0; i < N_SRC; i++) begin
         src_out_d[i] = (state_d != ST_IDLE) && (src_code_d == i[CODE_W-1:0]);
      end
      for (int i = 0; i < N_DST; i++) begin
         dst_in_d[i] = (state_d == ST_LATCH) && (dst_code_d == i[CODE_W-1:0]);
      end
      xfer_done_d = (state_d == ST_LATCH);
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q     <= ST_IDLE;
         src_code_q  <= '0;
         dst_code_q  <= '0;
         cnt_q       <= '0;
         src_out_q   <= '0;
         dst_in_q    <= '0;
         xfer_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_code_q  <= src_code_d;
         dst_code_q  <= dst_code_d;
         cnt_q       <= cnt_d;
         src_out_q   <= src_out_d;
         dst_in_q    <= dst_in_d;
         xfer_done_q <= xfer_done_d;
         err_q       <= err_d;
      end
   end

   assign src_out   = src_out_q;
   assign dst_in    = dst_in_q;
   assign xfer_done = xfer_done_q;
   assign err_code  = err_q;
   assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_transfer_sequencer
// Directed self-checking bench for bus_transfer_sequencer with hand-computed
// per-cycle expectations, followed by a random run guarded by invariant checks.
// ---------------------------------------------------------------------------
module tb_bus_transfer_sequencer;

   logic        clock;
   logic        clear;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_src;
   logic [4:0]  req_dst;
   logic [1:0]  req_wait;
   logic        flush;
   logic [25:0] src_out;
   logic [24:0] dst_in;
   logic        xfer_done;
   logic        busy;
   logic        err_code;

   int errors = 0;
   int checks = 0;
   bit rand_on = 1'b0;

   bus_transfer_sequencer dut (
      .clock     (clock),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_wait  (req_wait),
      .flush     (flush),
      .src_out   (src_out),
      .dst_in    (dst_in),
      .xfer_done (xfer_done),
      .busy      (busy),
      .err_code  (err_code)
   );

   // 10 time-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the request/flush inputs for the next rising edge.
   task automatic applyStimulus(input logic v, input logic [4:0] s,
                                input logic [4:0] d, input logic [1:0] w,
                                input logic f);
      req_valid = v;
      req_src   = s;
      req_dst   = d;
      req_wait  = w;
      flush     = f;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 2'd0, 1'b0);
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] oh(input int code);
      if (code < 0) return 32'd0;
      return 32'd1 << code;
   endfunction

   task automatic checkAll(input string tag, input int exp_src, input int exp_dst,
                           input logic exp_done, input logic exp_busy,
                           input logic exp_ready, input logic exp_err);
      checkOutput({tag, ".src_out"},   {6'd0, src_out},   oh(exp_src));
      checkOutput({tag, ".dst_in"},    {7'd0, dst_in},    oh(exp_dst));
      checkOutput({tag, ".xfer_done"}, {31'd0, xfer_done}, {31'd0, exp_done});
      checkOutput({tag, ".busy"},      {31'd0, busy},      {31'd0, exp_busy});
      checkOutput({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, exp_ready});
      checkOutput({tag, ".err_code"},  {31'd0, err_code},  {31'd0, exp_err});
   endtask

   // Invariants sampled mid-cycle during the random run.
   always @(negedge clock) begin
      if (rand_on) begin
         checkOutput("inv.src_onehot0", {31'd0, $onehot0(src_out)}, 32'd1);
         checkOutput("inv.dst_onehot0", {31'd0, $onehot0(dst_in)}, 32'd1);
         checkOutput("inv.dst_needs_src",
                     {31'd0, (dst_in == '0) || (src_out != '0)}, 32'd1);
      end
   end

   initial begin
      clear = 1'b0;
      idle();
      tick();
      tick();
      checkAll("reset", -1, -1, 0, 0, 1, 0);
      clear = 1'b1;

      // PC(20) -> MAR(20), wait 0
      applyStimulus(1'b1, 5'd20, 5'd20, 2'd0, 1'b0);
      tick();
      idle();
      checkAll("t1.c1", -1, -1, 0, 1, 1, 0);
      tick();
      checkAll("t1.c2", 20, 20, 1, 1, 1, 0);
      tick();
      checkAll("t1.c3", -1, -1, 0, 0, 1, 0);

      // MDR(21) -> IR(21), wait 2
      applyStimulus(1'b1, 5'd21, 5'd21, 2'd2, 1'b0);
      tick();
      idle();
      checkAll("t2.push", -1, -1, 0, 1, 1, 0);
      tick();
      checkAll("t2.drv1", 21, -1, 0, 1, 1, 0);
      tick();
      checkAll("t2.drv2", 21, -1, 0, 1, 1, 0);
      tick();
      checkAll("t2.latch", 21, 21, 1, 1, 1, 0);
      tick();
      checkAll("t2.done", -1, -1, 0, 0, 1, 0);

      // Fill queue behind a PC->Y wait 3 transfer, then drain back-to-back
      applyStimulus(1'b1, 5'd20, 5'd22, 2'd3, 1'b0);
      tick();
      checkAll("t3.e1", -1, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd1, 5'd22, 2'd0, 1'b0);   // R1 -> Y
      tick();
      checkAll("t3.e2", 20, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd2, 5'd23, 2'd0, 1'b0);   // R2 -> Z
      tick();
      checkAll("t3.e3", 20, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd16, 5'd3, 2'd0, 1'b0);   // HI -> R3
      tick();
      checkAll("t3.e4", 20, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd17, 5'd4, 2'd0, 1'b0);   // LO -> R4
      tick();
      checkAll("t3.e5_full", 20, 22, 1, 1, 0, 0);
      applyStimulus(1'b1, 5'd9, 5'd9, 2'd0, 1'b0);    // refused while full
      tick();
      idle();
      checkAll("t3.e6", 1, 22, 1, 1, 1, 0);
      tick();
      checkAll("t3.e7", 2, 23, 1, 1, 1, 0);
      tick();
      checkAll("t3.e8", 16, 3, 1, 1, 1, 0);
      tick();
      checkAll("t3.e9", 17, 4, 1, 1, 1, 0);
      tick();
      checkAll("t3.e10", -1, -1, 0, 0, 1, 0);

      // Out-of-range source, then out-of-range destination
      applyStimulus(1'b1, 5'd27, 5'd0, 2'd0, 1'b0);
      tick();
      idle();
      checkAll("t4.src_bad", -1, -1, 0, 0, 1, 1);
      tick();
      checkAll("t4.src_after", -1, -1, 0, 0, 1, 0);
      applyStimulus(1'b1, 5'd0, 5'd30, 2'd0, 1'b0);
      tick();
      idle();
      checkAll("t4.dst_bad", -1, -1, 0, 0, 1, 1);
      tick();
      checkAll("t4.dst_after", -1, -1, 0, 0, 1, 0);

      // Flush during DRIVE of a wait 3 head with two queued behind it
      applyStimulus(1'b1, 5'd1, 5'd2, 2'd3, 1'b0);
      tick();
      checkAll("t5.e1", -1, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd3, 5'd4, 2'd0, 1'b0);
      tick();
      checkAll("t5.e2", 1, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd5, 5'd6, 2'd0, 1'b0);
      tick();
      checkAll("t5.e3", 1, -1, 0, 1, 1, 0);
      applyStimulus(1'b1, 5'd7, 5'd8, 2'd0, 1'b1);    // dropped with flush
      tick();
      idle();
      checkAll("t5.flushed", -1, -1, 0, 0, 1, 0);
      tick();
      checkAll("t5.quiet1", -1, -1, 0, 0, 1, 0);
      tick();
      checkAll("t5.quiet2", -1, -1, 0, 0, 1, 0);
      applyStimulus(1'b1, 5'd5, 5'd5, 2'd0, 1'b0);    // R5 -> R5 self-load
      tick();
      idle();
      checkAll("t5.new_push", -1, -1, 0, 1, 1, 0);
      tick();
      checkAll("t5.new_latch", 5, 5, 1, 1, 1, 0);
      tick();
      checkAll("t5.new_done", -1, -1, 0, 0, 1, 0);

      // Reset during DRIVE of a wait 3 transfer
      applyStimulus(1'b1, 5'd2, 5'd3, 2'd3, 1'b0);
      tick();
      idle();
      checkAll("t6.push", -1, -1, 0, 1, 1, 0);
      tick();
      checkAll("t6.drive", 2, -1, 0, 1, 1, 0);
      clear = 1'b0;
      tick();
      clear = 1'b1;
      checkAll("t6.reset", -1, -1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkAll("t6.after", -1, -1, 0, 0, 1, 0);
      end

      // Random traffic with invariant checks, then drain
      rand_on = 1'b1;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 15) == 0));
         tick();
      end
      idle();
      repeat (25) tick();
      rand_on = 1'b0;
      checkAll("rand.drained", -1, -1, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
